sprite_draw_sequencer: RTL and testbench

- Parametrised N-channel draw sequencer. It takes plot requests from NUM_CH sprite engines (player, alien rows, bullets, ...) and gives exactly one engine ownership of the single pixel-plot port at a time.
- It arbitrates requests, muxes the owner's pixel stream onto x/y/colour/plot, and releases the port on the engine's finish.
- A per-grant watchdog stops a hung engine from locking the port.
- It sits between the sprite modules and the VGA adapter and replaces the fixed three-channel mux/FSM pair.

---
 rtl/sprite_seq_pkg.sv | 16 +
 rtl/seq_arbiter.sv | 41 ++++
 rtl/sprite_draw_sequencer.sv | 147 ++++++++++++++
 tb/tb_sprite_draw_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sprite_seq_pkg.sv
// Shared definitions for the sprite draw sequencer and the sprite engines that feed it.
package sprite_seq_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] STREAM  = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Coordinate/colour widths of the VGA adapter, shared with player/alien/bullet modules
   localparam int DEF_X_W = 9;
   localparam int DEF_Y_W = 8;
   localparam int DEF_C_W = 3;

endpackage

// File: rtl/seq_arbiter.sv
// Combinational winner select over the pending channels: fixed priority or
// round-robin starting just after the last granted channel.
module seq_arbiter import sprite_seq_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int MODE   = MODE_RR,
   localparam int P_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] pending_i,
   input  logic [P_W-1:0]    last_i,
   output logic [NUM_CH-1:0] win_o,
   output logic              any_o
);

   logic           found;
   logic [P_W-1:0] idx;

   always_comb begin
      win_o = '0;
      found = 1'b0;
      idx   = '0;
      any_o = |pending_i;
      if (MODE == MODE_FIXED) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pending_i[i]) begin
               win_o[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end else begin
         // k runs 1..NUM_CH so the last winner is visited last
         for (int k = 1; k <= NUM_CH; k++) begin
            idx = P_W'((int'(last_i) + k) % NUM_CH);
            if (!found && pending_i[idx]) begin
               win_o[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Hands the single VGA plot port to one sprite engine at a time, muxes its
// pixel stream through a register stage and forces release on a hung engine.
module sprite_draw_sequencer import sprite_seq_pkg::*; #(
   parameter int NUM_CH      = 4,
   parameter int X_W         = DEF_X_W,
   parameter int Y_W         = DEF_Y_W,
   parameter int C_W         = DEF_C_W,
   parameter int MODE        = MODE_RR,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       req,
   input  logic [NUM_CH*X_W-1:0]   ch_x,
   input  logic [NUM_CH*Y_W-1:0]   ch_y,
   input  logic [NUM_CH*C_W-1:0]   ch_colour,
   input  logic [NUM_CH-1:0]       ch_valid,
   input  logic [NUM_CH-1:0]       ch_fin,
   output logic [NUM_CH-1:0]       grant,
   output logic [X_W-1:0]          x,
   output logic [Y_W-1:0]          y,
   output logic [C_W-1:0]          colour,
   output logic                    plot,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int P_W  = $clog2(NUM_CH);
   localparam int WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

   logic [1:0]        state_q, state_d;
   logic [NUM_CH-1:0] pend_q, pend_d, grant_q, grant_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [C_W-1:0]    c_q, c_d;
   logic              plot_q, plot_d, terr_q, terr_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [P_W-1:0]    last_q, last_d;

   logic [NUM_CH-1:0] win;
   logic              any_pend;
   logic [P_W-1:0]    g_idx, win_idx;
   logic              sel_valid, sel_fin, wd_hit;

   seq_arbiter #(.NUM_CH(NUM_CH), .MODE(MODE)) u_arb (
      .pending_i (pend_q),
      .last_i    (last_q),
      .win_o     (win),
      .any_o     (any_pend)
   );

   always_comb begin
      g_idx   = '0;
      win_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_q[i]) g_idx   = P_W'(i);
         if (win[i])     win_idx = P_W'(i);
      end
   end

   assign sel_valid = ch_valid[g_idx];
   assign sel_fin   = ch_fin[g_idx];
   assign wd_hit    = (wd_q == WD_MAX);

   always_ff @(posedge CLOCK_50) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_pend) state_d = STREAM;
         STREAM:  if (sel_fin || wd_hit) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pend_d  = pend_q | req;
      grant_d = grant_q;
      x_d     = x_q;
      y_d     = y_q;
      c_d     = c_q;
      plot_d  = 1'b0;
      wd_d    = '0;
      terr_d  = terr_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (any_pend) begin
               grant_d = win;
               // a request landing on its own grant edge re-queues the channel
               pend_d  = (pend_q & ~win) | req;
               last_d  = win_idx;
            end
         end
         STREAM: begin
            plot_d = sel_valid;
            if (sel_valid) begin
               x_d = ch_x[g_idx*X_W +: X_W];
               y_d = ch_y[g_idx*Y_W +: Y_W];
               c_d = ch_colour[g_idx*C_W +: C_W];
            end
            wd_d = wd_q + WD_W'(1);
            if (wd_hit && !sel_fin) terr_d = 1'b1;
         end
         RELEASE: grant_d = '0;
         default: grant_d = '0;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         pend_q  <= '0;
         grant_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         c_q     <= '0;
         plot_q  <= 1'b0;
         wd_q    <= '0;
         terr_q  <= 1'b0;
         last_q  <= P_W'(NUM_CH - 1);
      end else begin
         pend_q  <= pend_d;
         grant_q <= grant_d;
         x_q     <= x_d;
         y_q     <= y_d;
         c_q     <= c_d;
         plot_q  <= plot_d;
         wd_q    <= wd_d;
         terr_q  <= terr_d;
         last_q  <= last_d;
      end
   end

   assign grant       = grant_q;
   assign x           = x_q;
   assign y           = y_q;
   assign colour      = c_q;
   assign plot        = plot_q;
   assign busy        = |grant_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench: a round-robin and a fixed-priority sequencer share one
// stimulus stream; expected grants and pixels are hand-derived.
module tb_sprite_draw_sequencer;
   import sprite_seq_pkg::*;

   localparam int N  = 4;
   localparam int XW = 9;
   localparam int YW = 8;
   localparam int CW = 3;

   logic          CLOCK_50 = 1'b0;
   logic          reset;
   logic [N-1:0]  req, ch_valid, ch_fin;
   logic [N*XW-1:0] ch_x;
   logic [N*YW-1:0] ch_y;
   logic [N*CW-1:0] ch_colour;

   logic [N-1:0]  grant_rr, grant_fx;
   logic [XW-1:0] x_rr, x_fx;
   logic [YW-1:0] y_rr, y_fx;
   logic [CW-1:0] c_rr, c_fx;
   logic          plot_rr, plot_fx, busy_rr, busy_fx, terr_rr, terr_fx;

   int n_vec = 0;
   int n_err = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   sprite_draw_sequencer #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW),
                           .MODE(MODE_RR), .TIMEOUT_CYC(16)) dut_rr (
      .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .ch_x(ch_x), .ch_y(ch_y),
      .ch_colour(ch_colour), .ch_valid(ch_valid), .ch_fin(ch_fin),
      .grant(grant_rr), .x(x_rr), .y(y_rr), .colour(c_rr), .plot(plot_rr),
      .busy(busy_rr), .timeout_err(terr_rr));

   sprite_draw_sequencer #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW),
                           .MODE(MODE_FIXED), .TIMEOUT_CYC(16)) dut_fx (
      .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .ch_x(ch_x), .ch_y(ch_y),
      .ch_colour(ch_colour), .ch_valid(ch_valid), .ch_fin(ch_fin),
      .grant(grant_fx), .x(x_fx), .y(y_fx), .colour(c_fx), .plot(plot_fx),
      .busy(busy_fx), .timeout_err(terr_fx));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic set_default();
      for (int i = 0; i < N; i++) begin
         ch_x[i*XW +: XW]      = XW'(100 + i);
         ch_y[i*YW +: YW]      = YW'(i);
         ch_colour[i*CW +: CW] = CW'(i);
      end
   endtask

   // waits for the next grant, checks owner and its single pixel, then waits for release
   task automatic wait_grant(input string tag, input int ri, input int fi);
      int n;
      logic [N-1:0] e_rr, e_fx;
      e_rr = N'(1) << ri;
      e_fx = N'(1) << fi;
      n = 0;
      while (grant_rr == '0 && n < 20) begin step(); n++; end
      check({tag, "_rr"}, 32'(grant_rr), 32'(e_rr));
      check({tag, "_fx"}, 32'(grant_fx), 32'(e_fx));
      step();
      check({tag, "_px"}, {22'd0, plot_rr, x_rr}, {22'd0, 1'b1, XW'(100 + ri)});
      n = 0;
      while (grant_rr != '0 && n < 20) begin step(); n++; end
      check({tag, "_rel"}, 32'(grant_rr), 32'd0);
   endtask

   int rr_ord[6]  = '{0, 1, 2, 3, 0, 1};
   int sim_rr[5]  = '{0, 1, 2, 3, 0};
   int sim_fx[5]  = '{0, 0, 1, 2, 3};

   initial begin
      reset = 1'b0; req = '0; ch_valid = '0; ch_fin = '0;
      set_default();
      step(); step();
      check("rst_grant", 32'(grant_rr), 32'd0);
      check("rst_out", {plot_rr, busy_rr, terr_rr, x_rr}, 32'd0);
      reset = 1'b1;

      // single channel stream on ch2
      req = 4'b0100; step(); req = '0; step();
      check("t1_grant", 32'(grant_rr), 32'h4);
      check("t1_busy", 32'(busy_rr), 32'd1);
      ch_x[2*XW +: XW] = 9'd10; ch_y[2*YW +: YW] = 8'd20; ch_colour[2*CW +: CW] = 3'd3;
      ch_valid = 4'b0100; step();
      check("t1_px0", {plot_rr, x_rr, y_rr, c_rr}, {1'b1, 9'd10, 8'd20, 3'd3});
      ch_x[2*XW +: XW] = 9'd11; step();
      check("t1_px1", {plot_rr, x_rr, y_rr, c_rr}, {1'b1, 9'd11, 8'd20, 3'd3});
      ch_x[2*XW +: XW] = 9'd12; ch_fin = 4'b0100; step();
      check("t1_px2", {plot_rr, x_rr, y_rr, c_rr}, {1'b1, 9'd12, 8'd20, 3'd3});
      check("t1_rel_grant", 32'(grant_rr), 32'h4);
      ch_valid = '0; ch_fin = '0; step();
      check("t1_done", {grant_rr, busy_rr, plot_rr, x_rr}, {4'h0, 1'b0, 1'b0, 9'd12});

      // isolation: ch3 valid/fin while ch1 owns the port
      set_default();
      req = 4'b0010; step(); req = '0; step();
      check("iso_grant", 32'(grant_rr), 32'h2);
      ch_x[1*XW +: XW] = 9'd50; ch_valid = 4'b1010; ch_fin = 4'b1000; step();
      check("iso_px", {grant_rr, plot_rr, x_rr}, {4'h2, 1'b1, 9'd50});
      ch_valid = 4'b1000; step();
      check("iso_hold", {grant_rr, plot_rr, x_rr}, {4'h2, 1'b0, 9'd50});
      ch_valid = '0; ch_fin = 4'b1010; step(); step();
      check("iso_rel", 32'(grant_rr), 32'd0);

      // reset mid-stream drops stream and the queued ch1 request
      set_default(); ch_fin = '0;
      req = 4'b0010; step(); req = '0; step();
      ch_valid = 4'b0010; req = 4'b0010; step(); req = '0;
      check("mrst_px", {grant_rr, plot_rr, x_rr}, {4'h2, 1'b1, 9'd101});
      reset = 1'b0; step(); reset = 1'b1; ch_valid = '0;
      check("mrst_out", {grant_rr, plot_rr, busy_rr, terr_rr}, 32'd0);
      repeat (4) step();
      check("mrst_pend_lost", 32'(grant_rr), 32'd0);

      // fairness with requests held on every channel
      req = 4'b1111; ch_valid = 4'b1111; ch_fin = 4'b1111; step();
      foreach (rr_ord[k]) wait_grant($sformatf("fair%0d", k), rr_ord[k], 0);
      req = '0;
      reset = 1'b0; step(); reset = 1'b1;

      // req[0] on ch0's own grant edge re-queues ch0 behind the others
      req = 4'b0001; step(); req = 4'b1111; step(); req = '0;
      foreach (sim_rr[k]) wait_grant($sformatf("sim%0d", k), sim_rr[k], sim_fx[k]);
      repeat (6) step();
      check("sim_idle", {grant_rr, grant_fx}, 32'd0);

      // watchdog: ch0 never finishes, ch2 queued behind it
      ch_valid = 4'b0100; ch_fin = 4'b0100;
      req = 4'b0001; step(); req = 4'b0100; step(); req = '0;
      check("wd_grant", {grant_rr, grant_fx}, {4'h1, 4'h1});
      repeat (15) step();
      check("wd_last_stream", {grant_rr, terr_rr, plot_rr}, {4'h1, 1'b0, 1'b0});
      step();
      check("wd_release", {grant_rr, terr_rr, terr_fx}, {4'h1, 1'b1, 1'b1});
      step();
      check("wd_freed", {grant_rr, terr_rr}, {4'h0, 1'b1});
      wait_grant("wd_next", 2, 2);
      check("wd_sticky", {terr_rr, terr_fx}, 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_tb: bench timed out, expected completion");
      $fatal(1);
   end

endmodule
